core_axi_arbiter: RTL and testbench

Two-master AXI-Lite arbiter that shares the single data/instruction memory port between the instruction-fetch unit (read-only master, IF) and the load/store stage `core_mem` (read/write master, MEM). It sits between the pipeline and the memory controller and serialises all traffic to one outstanding transaction at a time. Round-robin arbitration prevents a stream of loads/stores from starving fetch, and vice versa.

---
 rtl/core_axi_pkg.sv | 18 +
 rtl/core_axi_rr_pick.sv | 19 +
 rtl/core_axi_arbiter.sv | 165 ++++++++++++++++
 tb/tb_core_axi_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_axi_pkg.sv
// Shared encodings for the core AXI-Lite arbiter slice.
// State, response and requester-index constants.
package core_axi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_IF  = 2'd1,
    RD_MEM = 2'd2,
    WR_MEM = 2'd3
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned REQ_IF  = 0;
  localparam int unsigned REQ_MEM = 1;

endpackage

// File: rtl/core_axi_rr_pick.sv
// Two-way round-robin picker.
// On contention the requester that was not served last wins.
module core_axi_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (req == 2'b11): grant = last ? 2'b01 : 2'b10;
      (req == 2'b01): grant = 2'b01;
      (req == 2'b10): grant = 2'b10;
      default:        grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/core_axi_arbiter.sv
// Shares one AXI-Lite memory port between fetch (read-only)
// and core_mem (read/write), one transaction at a time.
module core_axi_arbiter
  import core_axi_pkg::*;
#(
  parameter int AXI_AWIDTH = 4,
  parameter int AXI_DWIDTH = 32
) (
  input  logic                    CLK,
  input  logic                    NRST,
  input  logic [AXI_AWIDTH-1:0]   IF_ARADDR,
  input  logic                    IF_ARVALID,
  output logic                    IF_ARREADY,
  output logic [AXI_DWIDTH-1:0]   IF_RDATA,
  output logic [1:0]              IF_RRESP,
  output logic                    IF_RVALID,
  input  logic                    IF_RREADY,
  input  logic [AXI_AWIDTH-1:0]   MEM_AWADDR,
  input  logic                    MEM_AWVALID,
  output logic                    MEM_AWREADY,
  input  logic [AXI_DWIDTH-1:0]   MEM_WDATA,
  input  logic [AXI_DWIDTH/8-1:0] MEM_WSTRB,
  input  logic                    MEM_WVALID,
  output logic                    MEM_WREADY,
  output logic [1:0]              MEM_BRESP,
  output logic                    MEM_BVALID,
  input  logic                    MEM_BREADY,
  input  logic [AXI_AWIDTH-1:0]   MEM_ARADDR,
  input  logic                    MEM_ARVALID,
  output logic                    MEM_ARREADY,
  output logic [AXI_DWIDTH-1:0]   MEM_RDATA,
  output logic [1:0]              MEM_RRESP,
  output logic                    MEM_RVALID,
  input  logic                    MEM_RREADY,
  output logic [AXI_AWIDTH-1:0]   S_AWADDR,
  output logic                    S_AWVALID,
  input  logic                    S_AWREADY,
  output logic [AXI_DWIDTH-1:0]   S_WDATA,
  output logic [AXI_DWIDTH/8-1:0] S_WSTRB,
  output logic                    S_WVALID,
  input  logic                    S_WREADY,
  input  logic [1:0]              S_BRESP,
  input  logic                    S_BVALID,
  output logic                    S_BREADY,
  output logic [AXI_AWIDTH-1:0]   S_ARADDR,
  output logic                    S_ARVALID,
  input  logic                    S_ARREADY,
  input  logic [AXI_DWIDTH-1:0]   S_RDATA,
  input  logic [1:0]              S_RRESP,
  input  logic                    S_RVALID,
  output logic                    S_RREADY
);

  state_t     state;
  logic       last_mem;
  logic       aw_done;
  logic       w_done;
  logic       ar_done;
  logic [1:0] req;
  logic [1:0] grant;

  assign req[REQ_IF]  = IF_ARVALID;
  assign req[REQ_MEM] = MEM_AWVALID | MEM_ARVALID;

  core_axi_rr_pick u_pick (
    .req   (req),
    .last  (last_mem),
    .grant (grant)
  );

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state    <= IDLE;
      last_mem <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      ar_done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          ar_done <= 1'b0;
          if (grant[REQ_MEM]) begin
            last_mem <= 1'b1;
            state    <= MEM_AWVALID ? WR_MEM : RD_MEM;
          end else if (grant[REQ_IF]) begin
            last_mem <= 1'b0;
            state    <= RD_IF;
          end
        end
        RD_IF, RD_MEM: begin
          if (S_ARVALID && S_ARREADY) ar_done <= 1'b1;
          if (S_RVALID && S_RREADY) state <= IDLE;
        end
        WR_MEM: begin
          if (S_AWVALID && S_AWREADY) aw_done <= 1'b1;
          if (S_WVALID && S_WREADY) w_done <= 1'b1;
          if (S_BVALID && S_BREADY) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address beats are gated after their handshake so a
  // still-asserted master VALID never issues a duplicate.
  always_comb begin
    IF_ARREADY  = 1'b0;
    IF_RDATA    = '0;
    IF_RRESP    = '0;
    IF_RVALID   = 1'b0;
    MEM_AWREADY = 1'b0;
    MEM_WREADY  = 1'b0;
    MEM_BRESP   = '0;
    MEM_BVALID  = 1'b0;
    MEM_ARREADY = 1'b0;
    MEM_RDATA   = '0;
    MEM_RRESP   = '0;
    MEM_RVALID  = 1'b0;
    S_AWADDR    = '0;
    S_AWVALID   = 1'b0;
    S_WDATA     = '0;
    S_WSTRB     = '0;
    S_WVALID    = 1'b0;
    S_BREADY    = 1'b0;
    S_ARADDR    = '0;
    S_ARVALID   = 1'b0;
    S_RREADY    = 1'b0;
    unique case (state)
      RD_IF: begin
        S_ARADDR   = IF_ARADDR;
        S_ARVALID  = IF_ARVALID & ~ar_done;
        IF_ARREADY = S_ARREADY & ~ar_done;
        IF_RDATA   = S_RDATA;
        IF_RRESP   = S_RRESP;
        IF_RVALID  = S_RVALID;
        S_RREADY   = IF_RREADY;
      end
      RD_MEM: begin
        S_ARADDR    = MEM_ARADDR;
        S_ARVALID   = MEM_ARVALID & ~ar_done;
        MEM_ARREADY = S_ARREADY & ~ar_done;
        MEM_RDATA   = S_RDATA;
        MEM_RRESP   = S_RRESP;
        MEM_RVALID  = S_RVALID;
        S_RREADY    = MEM_RREADY;
      end
      WR_MEM: begin
        S_AWADDR    = MEM_AWADDR;
        S_AWVALID   = MEM_AWVALID & ~aw_done;
        MEM_AWREADY = S_AWREADY & ~aw_done;
        S_WDATA     = MEM_WDATA;
        S_WSTRB     = MEM_WSTRB;
        S_WVALID    = MEM_WVALID & ~w_done;
        MEM_WREADY  = S_WREADY & ~w_done;
        MEM_BRESP   = S_BRESP;
        MEM_BVALID  = S_BVALID;
        S_BREADY    = MEM_BREADY;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_core_axi_arbiter.sv
// Directed bench for core_axi_arbiter.
// Slave side is driven by hand from the stimulus sequence.
module tb_core_axi_arbiter;
  import core_axi_pkg::*;

  logic        CLK;
  logic        NRST;
  logic [3:0]  IF_ARADDR;
  logic        IF_ARVALID, IF_ARREADY;
  logic [31:0] IF_RDATA;
  logic [1:0]  IF_RRESP;
  logic        IF_RVALID, IF_RREADY;
  logic [3:0]  MEM_AWADDR;
  logic        MEM_AWVALID, MEM_AWREADY;
  logic [31:0] MEM_WDATA;
  logic [3:0]  MEM_WSTRB;
  logic        MEM_WVALID, MEM_WREADY;
  logic [1:0]  MEM_BRESP;
  logic        MEM_BVALID, MEM_BREADY;
  logic [3:0]  MEM_ARADDR;
  logic        MEM_ARVALID, MEM_ARREADY;
  logic [31:0] MEM_RDATA;
  logic [1:0]  MEM_RRESP;
  logic        MEM_RVALID, MEM_RREADY;
  logic [3:0]  S_AWADDR;
  logic        S_AWVALID, S_AWREADY;
  logic [31:0] S_WDATA;
  logic [3:0]  S_WSTRB;
  logic        S_WVALID, S_WREADY;
  logic [1:0]  S_BRESP;
  logic        S_BVALID, S_BREADY;
  logic [3:0]  S_ARADDR;
  logic        S_ARVALID, S_ARREADY;
  logic [31:0] S_RDATA;
  logic [1:0]  S_RRESP;
  logic        S_RVALID, S_RREADY;

  int checks = 0;
  int failures = 0;
  int aw_cnt = 0;
  int w_cnt = 0;
  int aw0, w0;

  logic [11:0] vr;
  assign vr = {IF_ARREADY, IF_RVALID, MEM_AWREADY, MEM_WREADY,
               MEM_BVALID, MEM_ARREADY, MEM_RVALID, S_AWVALID,
               S_WVALID, S_BREADY, S_ARVALID, S_RREADY};

  core_axi_arbiter #(.AXI_AWIDTH(4), .AXI_DWIDTH(32)) dut (
    .CLK(CLK), .NRST(NRST),
    .IF_ARADDR(IF_ARADDR), .IF_ARVALID(IF_ARVALID),
    .IF_ARREADY(IF_ARREADY), .IF_RDATA(IF_RDATA),
    .IF_RRESP(IF_RRESP), .IF_RVALID(IF_RVALID),
    .IF_RREADY(IF_RREADY),
    .MEM_AWADDR(MEM_AWADDR), .MEM_AWVALID(MEM_AWVALID),
    .MEM_AWREADY(MEM_AWREADY), .MEM_WDATA(MEM_WDATA),
    .MEM_WSTRB(MEM_WSTRB), .MEM_WVALID(MEM_WVALID),
    .MEM_WREADY(MEM_WREADY), .MEM_BRESP(MEM_BRESP),
    .MEM_BVALID(MEM_BVALID), .MEM_BREADY(MEM_BREADY),
    .MEM_ARADDR(MEM_ARADDR), .MEM_ARVALID(MEM_ARVALID),
    .MEM_ARREADY(MEM_ARREADY), .MEM_RDATA(MEM_RDATA),
    .MEM_RRESP(MEM_RRESP), .MEM_RVALID(MEM_RVALID),
    .MEM_RREADY(MEM_RREADY),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID),
    .S_AWREADY(S_AWREADY), .S_WDATA(S_WDATA),
    .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID),
    .S_WREADY(S_WREADY), .S_BRESP(S_BRESP),
    .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID),
    .S_ARREADY(S_ARREADY), .S_RDATA(S_RDATA),
    .S_RRESP(S_RRESP), .S_RVALID(S_RVALID),
    .S_RREADY(S_RREADY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (S_AWVALID && S_AWREADY) aw_cnt++;
    if (S_WVALID && S_WREADY) w_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Called one step after the grant edge; serves one read.
  task automatic serve_read(input bit to_mem, input logic [3:0] addr,
                            input logic [31:0] data,
                            input logic [1:0] resp, input int wt);
    #1;
    chk("rd_arvalid", {31'd0, S_ARVALID}, 32'd1);
    chk("rd_araddr", {28'd0, S_ARADDR}, {28'd0, addr});
    S_ARREADY = 1'b1;
    #1;
    chk("rd_arready", {31'd0, to_mem ? MEM_ARREADY : IF_ARREADY}, 32'd1);
    tick();
    S_ARREADY = 1'b0;
    if (to_mem) MEM_ARVALID = 1'b0;
    else IF_ARVALID = 1'b0;
    repeat (wt) tick();
    S_RVALID = 1'b1;
    S_RDATA  = data;
    S_RRESP  = resp;
    #1;
    if (to_mem) begin
      chk("mem_rdata", MEM_RDATA, data);
      chk("mem_rresp", {30'd0, MEM_RRESP}, {30'd0, resp});
      chk("mem_rvalid", {31'd0, MEM_RVALID}, 32'd1);
      chk("if_quiet", {IF_RDATA[30:0], IF_RVALID}, 32'd0);
    end else begin
      chk("if_rdata", IF_RDATA, data);
      chk("if_rresp", {30'd0, IF_RRESP}, {30'd0, resp});
      chk("if_rvalid", {31'd0, IF_RVALID}, 32'd1);
      chk("mem_quiet", {MEM_RDATA[30:0], MEM_RVALID}, 32'd0);
    end
    tick();
    S_RVALID = 1'b0;
    S_RDATA  = '0;
    S_RRESP  = '0;
    #1;
    chk("rd_back_idle", {20'd0, vr}, 32'd0);
  endtask

  initial begin
    NRST = 0;
    IF_ARADDR = 0; IF_ARVALID = 0; IF_RREADY = 0;
    MEM_AWADDR = 0; MEM_AWVALID = 0; MEM_WDATA = 0;
    MEM_WSTRB = 0; MEM_WVALID = 0; MEM_BREADY = 0;
    MEM_ARADDR = 0; MEM_ARVALID = 0; MEM_RREADY = 0;
    S_AWREADY = 0; S_WREADY = 0; S_BRESP = 0; S_BVALID = 0;
    S_ARREADY = 0; S_RDATA = 0; S_RRESP = 0; S_RVALID = 0;
    repeat (2) tick();
    chk("reset_vr", {20'd0, vr}, 32'd0);
    NRST = 1;

    // Spurious slave beats in IDLE are dropped
    S_RVALID = 1; S_BVALID = 1;
    #1;
    chk("spur_r", {30'd0, IF_RVALID, MEM_RVALID}, 32'd0);
    chk("spur_b", {31'd0, MEM_BVALID}, 32'd0);
    S_RVALID = 0; S_BVALID = 0;

    // IF-only read, response two cycles after AR
    IF_ARADDR = 4'h4; IF_ARVALID = 1; IF_RREADY = 1; MEM_RREADY = 1;
    #1;
    chk("if_idle_noar", {31'd0, S_ARVALID}, 32'd0);
    tick();
    serve_read(1'b0, 4'h4, 32'hDEADBEEF, RESP_OKAY, 2);

    // Contention after reset: MEM first, then IF, then MEM
    NRST = 0;
    tick();
    NRST = 1;
    IF_ARADDR = 4'h1; IF_ARVALID = 1;
    MEM_ARADDR = 4'h2; MEM_ARVALID = 1;
    tick();
    serve_read(1'b1, 4'h2, 32'h0000_0022, RESP_OKAY, 0);
    MEM_ARADDR = 4'h3; MEM_ARVALID = 1;
    tick();
    serve_read(1'b0, 4'h1, 32'h0000_0011, RESP_OKAY, 0);
    tick();
    serve_read(1'b1, 4'h3, 32'h0000_0033, RESP_OKAY, 0);

    // Store with W accepted two cycles before AW
    aw0 = aw_cnt; w0 = w_cnt;
    MEM_AWADDR = 4'h8; MEM_AWVALID = 1;
    MEM_WDATA = 32'h0000AB00; MEM_WSTRB = 4'b0010; MEM_WVALID = 1;
    MEM_BREADY = 1;
    tick();
    chk("st_aw", {S_AWVALID, S_WVALID, 26'd0, S_AWADDR}, 32'hC000_0008);
    chk("st_wdata", S_WDATA, 32'h0000AB00);
    chk("st_wstrb", {28'd0, S_WSTRB}, 32'd2);
    S_WREADY = 1;
    #1;
    chk("st_wready", {30'd0, MEM_WREADY, MEM_AWREADY}, 32'd2);
    tick();
    chk("st_w_gated", {30'd0, S_WVALID, MEM_WREADY}, 32'd0);
    tick();
    S_AWREADY = 1;
    #1;
    chk("st_awready", {31'd0, MEM_AWREADY}, 32'd1);
    tick();
    chk("st_aw_gated", {31'd0, S_AWVALID}, 32'd0);
    S_AWREADY = 0; S_WREADY = 0;
    MEM_AWVALID = 0; MEM_WVALID = 0;
    S_BVALID = 1; S_BRESP = RESP_OKAY;
    #1;
    chk("st_b", {29'd0, MEM_BVALID, MEM_BRESP}, 32'h4);
    tick();
    S_BVALID = 0;
    #1;
    chk("st_idle", {20'd0, vr}, 32'd0);
    chk("st_beats", aw_cnt - aw0 + 16 * (w_cnt - w0), 32'd17);

    // AW+AR together: write first, then SLVERR read
    MEM_AWADDR = 4'hC; MEM_AWVALID = 1;
    MEM_WDATA = 32'h1234_5678; MEM_WSTRB = 4'hF; MEM_WVALID = 1;
    MEM_ARADDR = 4'h6; MEM_ARVALID = 1;
    tick();
    chk("wr_first", {30'd0, S_AWVALID, S_ARVALID}, 32'd2);
    S_AWREADY = 1; S_WREADY = 1;
    tick();
    S_AWREADY = 0; S_WREADY = 0;
    MEM_AWVALID = 0; MEM_WVALID = 0;
    S_BVALID = 1;
    #1;
    chk("wr_b_noar", {30'd0, MEM_BVALID, S_ARVALID}, 32'd2);
    tick();
    S_BVALID = 0;
    #1;
    chk("wr_gap", {31'd0, S_ARVALID}, 32'd0);
    tick();
    serve_read(1'b1, 4'h6, 32'hCAFE_F00D, RESP_SLVERR, 1);

    // Reset in WR_MEM after AW, then a fresh store
    aw0 = aw_cnt;
    MEM_AWADDR = 4'hA; MEM_AWVALID = 1;
    MEM_WDATA = 32'h5555_AAAA; MEM_WSTRB = 4'h3; MEM_WVALID = 1;
    tick();
    S_AWREADY = 1;
    tick();
    S_AWREADY = 0;
    #1;
    chk("rst_aw_done", {30'd0, S_AWVALID, S_WVALID}, 32'd1);
    NRST = 0;
    tick();
    chk("rst_vr", {20'd0, vr}, 32'd0);
    chk("rst_addr", {28'd0, S_AWADDR}, 32'd0);
    NRST = 1;
    tick();
    chk("rst_fresh_aw", {30'd0, S_AWVALID, S_WVALID}, 32'd3);
    S_AWREADY = 1; S_WREADY = 1;
    tick();
    S_AWREADY = 0; S_WREADY = 0;
    MEM_AWVALID = 0; MEM_WVALID = 0;
    S_BVALID = 1;
    tick();
    S_BVALID = 0;
    #1;
    chk("rst_aw_count", aw_cnt - aw0, 32'd2);
    chk("rst_end_idle", {20'd0, vr}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
